// File: rtl/alu_pkg.sv
// Opcode encodings and buffer-state types shared by the ALU, the arbiter wrapper and the bench.
package alu_pkg;

  localparam int unsigned ALU_OP_W    = 4;
  localparam int unsigned NUM_ALU_OPS = 6;

  localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'd0;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'd1;
  localparam logic [ALU_OP_W-1:0] ALU_OR  = 4'd2;
  localparam logic [ALU_OP_W-1:0] ALU_CMP = 4'd3;
  localparam logic [ALU_OP_W-1:0] ALU_SLL = 4'd4;
  localparam logic [ALU_OP_W-1:0] ALU_SRA = 4'd5;

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_e;

  function automatic logic op_is_legal(input logic [ALU_OP_W-1:0] op, input int unsigned num_ops);
    return (32'(op) < num_ops);
  endfunction

endpackage

// File: rtl/alu.sv
// Purely combinational 32-bit ALU; unknown opcodes produce zero.
module alu
  import alu_pkg::*;
(
  input  logic [31:0]         a_i,
  input  logic [31:0]         b_i,
  input  logic [ALU_OP_W-1:0] op_i,
  output logic [31:0]         y_o
);

  // Opcode decode and result select
  always_comb begin
    y_o = 32'd0;
    case (op_i)
      ALU_ADD: y_o = a_i + b_i;
      ALU_SUB: y_o = a_i - b_i;
      ALU_OR:  y_o = a_i | b_i;
      ALU_CMP: begin
        if ($signed(a_i) > $signed(b_i)) begin
          y_o = 32'd1;
        end else if (a_i == b_i) begin
          y_o = 32'd0;
        end else begin
          y_o = 32'hFFFF_FFFF;
        end
      end
      ALU_SLL: y_o = a_i << b_i;
      ALU_SRA: y_o = $unsigned($signed(b_i) >>> a_i[4:0]);
      default: y_o = 32'd0;
    endcase
  end

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the priority pointer moves only when a grant is actually issued.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic [1:0] gnt_o
);

  logic prio_q;
  logic prio_d;

  // Grant selection; prio_q names the port that wins a conflict
  always_comb begin
    gnt_o = 2'b00;
    if (!en_i) begin
      gnt_o = 2'b00;
    end else begin
      case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        2'b11:   gnt_o = prio_q ? 2'b10 : 2'b01;
        default: gnt_o = 2'b00;
      endcase
    end
  end

  // Hand priority to the port that was not just served
  always_comb begin
    prio_d = prio_q;
    if (gnt_o[0]) begin
      prio_d = 1'b1;
    end else if (gnt_o[1]) begin
      prio_d = 1'b0;
    end else begin
      prio_d = prio_q;
    end
  end

  // Pointer register; port 0 wins the first conflict after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/alu_share_arb.sv
// Shares one ALU between two valid/ready requesters with a one-entry registered response buffer.
module alu_share_arb
  import alu_pkg::*;
#(
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned NUM_OPS = NUM_ALU_OPS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [31:0]         req_a0,
  input  logic [31:0]         req_b0,
  input  logic [31:0]         req_a1,
  input  logic [31:0]         req_b1,
  input  logic [ALU_OP_W-1:0] req_op0,
  input  logic [ALU_OP_W-1:0] req_op1,
  input  logic [TAG_W-1:0]    req_tag0,
  input  logic [TAG_W-1:0]    req_tag1,
  output logic [1:0]          rsp_valid,
  input  logic [1:0]          rsp_ready,
  output logic [31:0]         rsp_data,
  output logic [TAG_W-1:0]    rsp_tag,
  output logic                rsp_err
);

  buf_state_e          state_q, state_d;
  logic [31:0]         data_q, data_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic                owner_q, owner_d;
  logic                err_q, err_d;

  logic [1:0]          gnt_s;
  logic                sel_s;
  logic                accept_s;
  logic                drain_s;
  logic                can_accept_s;
  logic [31:0]         alu_a_s, alu_b_s, alu_y_s;
  logic [ALU_OP_W-1:0] alu_op_s;
  logic [TAG_W-1:0]    sel_tag_s;
  logic                legal_s;

  assign drain_s      = (state_q == BUF_FULL) && rsp_ready[owner_q];
  assign can_accept_s = (state_q == BUF_EMPTY) || drain_s;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req_i (req_valid),
    .en_i  (can_accept_s),
    .gnt_o (gnt_s)
  );

  // The pointer resets asynchronously too, but ready must also drop while reset is held
  assign req_ready = gnt_s & {rst_n, rst_n};
  assign accept_s  = |gnt_s;
  assign sel_s     = gnt_s[1];

  assign alu_a_s   = sel_s ? req_a1   : req_a0;
  assign alu_b_s   = sel_s ? req_b1   : req_b0;
  assign alu_op_s  = sel_s ? req_op1  : req_op0;
  assign sel_tag_s = sel_s ? req_tag1 : req_tag0;
  assign legal_s   = op_is_legal(alu_op_s, NUM_OPS);

  alu u_alu (
    .a_i  (alu_a_s),
    .b_i  (alu_b_s),
    .op_i (alu_op_s),
    .y_o  (alu_y_s)
  );

  // Buffer state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BUF_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next buffer state: an accept always (re)fills, a bare drain empties
  always_comb begin
    state_d = state_q;
    if (accept_s) begin
      state_d = BUF_FULL;
    end else if (drain_s) begin
      state_d = BUF_EMPTY;
    end else begin
      state_d = state_q;
    end
  end

  // Buffer payload next values; only an accept changes the contents
  always_comb begin
    data_d  = data_q;
    tag_d   = tag_q;
    owner_d = owner_q;
    err_d   = err_q;
    if (accept_s) begin
      data_d  = legal_s ? alu_y_s : 32'd0;
      tag_d   = sel_tag_s;
      owner_d = sel_s;
      err_d   = !legal_s;
    end else begin
      data_d  = data_q;
      tag_d   = tag_q;
      owner_d = owner_q;
      err_d   = err_q;
    end
  end

  // Buffer payload registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= 32'd0;
      tag_q   <= '0;
      owner_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      tag_q   <= tag_d;
      owner_q <= owner_d;
      err_q   <= err_d;
    end
  end

  // Response outputs decoded straight from registers
  always_comb begin
    rsp_valid = 2'b00;
    if (state_q == BUF_FULL) begin
      rsp_valid = owner_q ? 2'b10 : 2'b01;
    end else begin
      rsp_valid = 2'b00;
    end
    rsp_data = data_q;
    rsp_tag  = tag_q;
    rsp_err  = err_q;
  end

endmodule

// File: tb/tb_alu_share_arb.sv
// Table-driven directed vectors, a mid-operation reset sequence and randomized traffic vs. a reference model.
module tb_alu_share_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
  logic [31:0] req_a0, req_b0, req_a1, req_b1, rsp_data;
  logic [3:0]  req_op0, req_op1, req_tag0, req_tag1, rsp_tag;
  logic        rsp_err;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  alu_share_arb #(.TAG_W(4), .NUM_OPS(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .req_op0(req_op0), .req_op1(req_op1), .req_tag0(req_tag0), .req_tag1(req_tag1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_tag(rsp_tag), .rsp_err(rsp_err)
  );

  typedef struct {
    logic [1:0]  v;
    logic [3:0]  op0; logic [31:0] a0; logic [31:0] b0; logic [3:0] t0;
    logic [3:0]  op1; logic [31:0] a1; logic [31:0] b1; logic [3:0] t1;
    logic [1:0]  rr;
    logic [1:0]  x_rdy;
    logic [1:0]  x_vld;
    logic [31:0] x_data;
    logic [3:0]  x_tag;
    logic        x_err;
  } vec_t;

  vec_t tbl[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic vec_t mk(input logic [1:0] v,
      input logic [3:0] op0, input logic [31:0] a0, input logic [31:0] b0, input logic [3:0] t0,
      input logic [3:0] op1, input logic [31:0] a1, input logic [31:0] b1, input logic [3:0] t1,
      input logic [1:0] rr, input logic [1:0] x_rdy, input logic [1:0] x_vld,
      input logic [31:0] x_data, input logic [3:0] x_tag, input logic x_err);
    vec_t r;
    r.v = v; r.op0 = op0; r.a0 = a0; r.b0 = b0; r.t0 = t0;
    r.op1 = op1; r.a1 = a1; r.b1 = b1; r.t1 = t1; r.rr = rr;
    r.x_rdy = x_rdy; r.x_vld = x_vld; r.x_data = x_data; r.x_tag = x_tag; r.x_err = x_err;
    return r;
  endfunction

  // Reference ALU from the opcode definitions; bit 32 flags an illegal opcode
  function automatic logic [32:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    int sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = int'(a % 32'd32);
    case (op)
      4'd0: return {1'b0, a + b};
      4'd1: return {1'b0, a - b};
      4'd2: return {1'b0, a | b};
      4'd3: return {1'b0, (sa > sb) ? 32'd1 : ((sa == sb) ? 32'd0 : 32'hFFFF_FFFF)};
      4'd4: return {1'b0, (b >= 32'd32) ? 32'd0 : (a << b)};
      4'd5: return {1'b0, b[31] ? ~((~b) >> sh) : (b >> sh)};
      default: return {1'b1, 32'd0};
    endcase
  endfunction

  task automatic drive(input vec_t e);
    req_valid = e.v; rsp_ready = e.rr;
    req_op0 = e.op0; req_a0 = e.a0; req_b0 = e.b0; req_tag0 = e.t0;
    req_op1 = e.op1; req_a1 = e.a1; req_b1 = e.b1; req_tag1 = e.t1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t idle;
    logic full_m; int owner_m; int prio_m; logic [31:0] data_m; logic [3:0] tag_m; logic err_m;
    logic [32:0] r;

    idle = mk(2'b00, 4'd0, 32'd0, 32'd0, 4'd0, 4'd0, 32'd0, 32'd0, 4'd0, 2'b00, 2'b00, 2'b00, 32'd0, 4'd0, 1'b0);
    tbl[0]  = mk(2'b01, 4'd0, 32'd3, 32'd4, 4'd5, 4'd0, 32'd0, 32'd0, 4'd0, 2'b00, 2'b01, 2'b01, 32'd7, 4'd5, 1'b0);
    tbl[1]  = mk(2'b11, 4'd0, 32'd1, 32'd1, 4'd1, 4'd1, 32'd10, 32'd3, 4'd2, 2'b01, 2'b10, 2'b10, 32'd7, 4'd2, 1'b0);
    tbl[2]  = mk(2'b11, 4'd0, 32'd1, 32'd1, 4'd1, 4'd1, 32'd10, 32'd3, 4'd2, 2'b11, 2'b01, 2'b01, 32'd2, 4'd1, 1'b0);
    tbl[3]  = mk(2'b11, 4'd0, 32'd1, 32'd1, 4'd1, 4'd1, 32'd10, 32'd3, 4'd2, 2'b11, 2'b10, 2'b10, 32'd7, 4'd2, 1'b0);
    tbl[4]  = mk(2'b11, 4'd0, 32'd1, 32'd1, 4'd1, 4'd1, 32'd10, 32'd3, 4'd2, 2'b11, 2'b01, 2'b01, 32'd2, 4'd1, 1'b0);
    tbl[5]  = mk(2'b10, 4'd0, 32'd0, 32'd0, 4'd0, 4'd3, 32'hFFFF_FFFF, 32'd1, 4'd3, 2'b11, 2'b10, 2'b10, 32'hFFFF_FFFF, 4'd3, 1'b0);
    tbl[6]  = mk(2'b10, 4'd0, 32'd0, 32'd0, 4'd0, 4'd3, 32'd5, 32'd5, 4'd4, 2'b10, 2'b10, 2'b10, 32'd0, 4'd4, 1'b0);
    tbl[7]  = mk(2'b10, 4'd0, 32'd0, 32'd0, 4'd0, 4'd3, 32'd1, 32'hFFFF_FFFF, 4'd5, 2'b10, 2'b10, 2'b10, 32'd1, 4'd5, 1'b0);
    tbl[8]  = mk(2'b01, 4'd5, 32'd4, 32'h8000_0000, 4'd6, 4'd0, 32'd0, 32'd0, 4'd0, 2'b10, 2'b01, 2'b01, 32'hF800_0000, 4'd6, 1'b0);
    tbl[9]  = mk(2'b01, 4'd4, 32'd1, 32'd4, 4'd7, 4'd0, 32'd0, 32'd0, 4'd0, 2'b01, 2'b01, 2'b01, 32'h10, 4'd7, 1'b0);
    tbl[10] = mk(2'b11, 4'd0, 32'd1, 32'd1, 4'd1, 4'd1, 32'd10, 32'd3, 4'd2, 2'b00, 2'b00, 2'b01, 32'h10, 4'd7, 1'b0);
    tbl[11] = tbl[10];
    tbl[12] = tbl[10];
    tbl[13] = mk(2'b11, 4'd0, 32'd1, 32'd1, 4'd1, 4'd1, 32'd10, 32'd3, 4'd2, 2'b10, 2'b00, 2'b01, 32'h10, 4'd7, 1'b0);
    tbl[14] = mk(2'b11, 4'd0, 32'd1, 32'd1, 4'd1, 4'd1, 32'd10, 32'd3, 4'd2, 2'b01, 2'b10, 2'b10, 32'd7, 4'd2, 1'b0);
    tbl[15] = mk(2'b01, 4'd9, 32'd5, 32'd6, 4'd9, 4'd0, 32'd0, 32'd0, 4'd0, 2'b10, 2'b01, 2'b01, 32'd0, 4'd9, 1'b1);
    tbl[16] = mk(2'b00, 4'd0, 32'd0, 32'd0, 4'd0, 4'd0, 32'd0, 32'd0, 4'd0, 2'b01, 2'b00, 2'b00, 32'd0, 4'd0, 1'b0);
    tbl[17] = mk(2'b00, 4'd0, 32'd0, 32'd0, 4'd0, 4'd0, 32'd0, 32'd0, 4'd0, 2'b00, 2'b00, 2'b00, 32'd0, 4'd0, 1'b0);

    // Reset state, with both ports requesting
    drive(idle);
    req_valid = 2'b11;
    rst_n = 1'b0;
    #1;
    check("reset_req_ready", 32'(req_ready), 32'd0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_data", rsp_data, 32'd0);
    check("reset_rsp_tag", 32'(rsp_tag), 32'd0);
    check("reset_rsp_err", 32'(rsp_err), 32'd0);
    drive(idle);
    do_reset();

    // Directed table
    for (int i = 0; i < 18; i++) begin
      drive(tbl[i]);
      #1;
      check($sformatf("tbl%0d_req_ready", i), 32'(req_ready), 32'(tbl[i].x_rdy));
      @(posedge clk);
      #1;
      check($sformatf("tbl%0d_rsp_valid", i), 32'(rsp_valid), 32'(tbl[i].x_vld));
      if (tbl[i].x_vld != 2'b00) begin
        check($sformatf("tbl%0d_rsp_data", i), rsp_data, tbl[i].x_data);
        check($sformatf("tbl%0d_rsp_tag", i), 32'(rsp_tag), 32'(tbl[i].x_tag));
        check($sformatf("tbl%0d_rsp_err", i), 32'(rsp_err), 32'(tbl[i].x_err));
      end
    end

    // Asynchronous reset while FULL with both ports waiting
    drive(tbl[10]);
    @(posedge clk);
    #1;
    check("midrst_full_before", 32'(rsp_valid != 2'b00), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("postrst_req_ready", 32'(req_ready), 32'b01);
    @(posedge clk);
    #1;
    check("postrst_rsp_valid", 32'(rsp_valid), 32'b01);
    check("postrst_rsp_data", rsp_data, 32'd2);

    // Randomized traffic against the reference model
    drive(idle);
    do_reset();
    full_m = 1'b0; owner_m = 0; prio_m = 0; data_m = 32'd0; tag_m = 4'd0; err_m = 1'b0;
    for (int c = 0; c < 600; c++) begin
      int gi;
      logic can;
      req_valid = 2'($urandom_range(0, 3));
      rsp_ready = 2'($urandom_range(0, 3));
      req_op0 = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 5));
      req_op1 = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 5));
      req_a0 = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      req_b0 = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      req_a1 = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      req_b1 = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      req_tag0 = 4'($urandom_range(0, 15));
      req_tag1 = 4'($urandom_range(0, 15));
      #1;
      can = !full_m || rsp_ready[owner_m];
      gi = -1;
      if (can) begin
        if (req_valid == 2'b11) gi = prio_m;
        else if (req_valid == 2'b01) gi = 0;
        else if (req_valid == 2'b10) gi = 1;
      end
      check($sformatf("rnd%0d_req_ready", c), 32'(req_ready), (gi < 0) ? 32'd0 : (32'd1 << gi));
      check($sformatf("rnd%0d_rsp_valid", c), 32'(rsp_valid), full_m ? (32'd1 << owner_m) : 32'd0);
      if (full_m) begin
        check($sformatf("rnd%0d_rsp_data", c), rsp_data, data_m);
        check($sformatf("rnd%0d_rsp_tag", c), 32'(rsp_tag), 32'(tag_m));
        check($sformatf("rnd%0d_rsp_err", c), 32'(rsp_err), 32'(err_m));
      end
      if (gi == 0) begin
        r = ref_alu(req_op0, req_a0, req_b0);
        tag_m = req_tag0;
      end else if (gi == 1) begin
        r = ref_alu(req_op1, req_a1, req_b1);
        tag_m = req_tag1;
      end
      if (gi >= 0) begin
        full_m = 1'b1; owner_m = gi; prio_m = 1 - gi;
        data_m = r[31:0]; err_m = r[32];
      end else if (full_m && rsp_ready[owner_m]) begin
        full_m = 1'b0;
      end
      @(posedge clk);
      #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
